hazard_sb: RTL and testbench
============================

// Module: hazard_sb
// PURPOSE
//  Next-generation pipeline hazard unit for the 5-stage core. Combines the existing forwarding and stall logic
//  (load-use, branch compare) with a pending-write scoreboard for the multi-cycle MDU (mult/div) writing a GPR.
//  Sits beside the datapath. Drives stall/flush/forward selects for F/D/E and the MDU writeback strobe.
// PARAMETERS
//  NREG     32               number of architectural GPRs (reg 0 hardwired zero)
//  RW       $clog2(NREG)     register index width
//  MDU_LAT  32               MDU issue-to-writeback latency in cycles; legal range 2..256
// PORTS
//  clk          in   1   clock, rising edge
//  resetn       in   1   synchronous reset, active-low
//  rsD,rtD      in   RW  D-stage source regs
//  writeregD    in   RW  D-stage destination reg
//  regwriteD    in   1   D-stage instruction writes a GPR
//  branchD      in   1   D-stage branch compare
//  mdu_opD      in   1   D-stage instruction is an MDU op
//  rsE,rtE      in   RW  E-stage source regs
//  writeregE    in   RW  E-stage destination reg
//  regwriteE    in   1   E-stage write enable
//  memtoregE    in   1   E-stage is a load
//  mdu_issueE   in   1   E-stage MDU op is issuing this cycle
//  mdu_early    in   1   MDU result ready before MDU_LAT (early-out divide)
//  writeregM    in   RW  M-stage destination reg
//  regwriteM    in   1   M-stage write enable
//  memtoregM    in   1   M-stage is a load
//  writeregW    in   RW  W-stage destination reg
//  regwriteW    in   1   W-stage write enable
//  exc_flush    in   1   exception: kill all in-flight work
//  stallF,stallD out 1   hold PC / IF-ID register
//  flushE       out  1   bubble into ID-EX
//  forwardaD,forwardbD out 1  branch-compare bypass from M
//  forwardaE,forwardbE out 2  ALU operand select: 00 regfile, 01 W, 10 M
//  mdu_busy     out  1   MDU tracker not IDLE
//  mdu_wb       out  1   one-cycle strobe: MDU writes mdu_wbreg this cycle
//  mdu_wbreg    out  RW  destination of pending MDU write
//  perf_lw,perf_br,perf_mdu out 32  stall-cycle counters (see CONFIGURATION)
// BEHAVIOUR
//  Forwarding is combinational. Reg 0 is never matched. A match in M has priority over a match in W.
//  forwardaD/bD assert when rsD/rtD==writeregM and regwriteM.
//  lwstall = memtoregE & (rtE==rsD | rtE==rtD).
//  brstall = branchD & (regwriteE & writeregE∈{rsD,rtD} | memtoregM & writeregM∈{rsD,rtD}).
//  mdustall applies while the pending dest pd is valid (state!=IDLE, pd!=0), and on any of these:
//   - rsD==pd or rtD==pd (RAW)
//   - regwriteD & writeregD==pd (WAW)
//   - mdu_opD & (state!=IDLE | mdu_issueE) (structural)
//  stallD = stallF = flushE = lwstall|brstall|mdustall. exc_flush forces flushE=1 and stallD=stallF=0.
//  Tracker FSM: IDLE -> BUSY -> WB -> IDLE.
//   - Issue is accepted when mdu_issueE & state==IDLE & ~exc_flush. On accept, pd<=writeregE and cnt<=MDU_LAT-2.
//   - BUSY: cnt decrements. Go to WB when cnt==0 or mdu_early.
//   - WB: mdu_wb=1 and mdu_wbreg=pd for exactly one cycle. Next state is IDLE.
//   - Timing: issue seen in cycle t gives mdu_wb in cycle t+MDU_LAT, or in cycle t'+1 if mdu_early is seen in cycle t' of BUSY.
//   - RAW/WAW stall holds through the WB cycle. The regfile is write-first, so the consumer reads the correct value in cycle WB+1.
//   - mdu_issueE while not IDLE cannot occur; the structural stall prevents it. The tracker ignores it.
//   - exc_flush in any state gives state<=IDLE and pd<=0 next edge, with no mdu_wb. exc_flush wins over a simultaneous issue.
//  Reset (resetn=0 at edge): state IDLE, cnt 0, pd 0, perf counters 0. Reset mid-operation abandons the MDU op with no mdu_wb.
//  After reset, all combinational outputs settle to 0 with idle inputs.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - perf_lw/br/mdu each +1 per cycle their cause asserts; causes are counted independently and may overlap
//   - counters wrap at 2^32 and are cleared by reset only
//   - a cycle with exc_flush does not count
//  HAZARD_PERF_EN undefined: perf_* ports tied to 32'd0, no counter flops.
// STRUCTURE
//  hazard_pkg:
//   - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
//   - MDU FSM state typedef (IDLE/BUSY/WB)
//   - stall cause enum
//  Sub-module mdu_tracker: FSM, counter, pd register, mdu_wb/mdu_wbreg. hazard_sb owns forwarding/stall combine/perf.
// TESTING
//  1. Load then use: lw $8 in E (memtoregE=1, rtE=8), rsD=8 -> stallD=stallF=flushE=1 for 1 cycle; next cycle forwardaE=2'b01.
//  2. Dual match: rsE=5 with writeregM=5, writeregW=5, both regwrite -> forwardaE=2'b10. rsE=0 with the same matches -> 2'b00.
//  3. MDU_LAT=4: issue writeregE=9 at t -> mdu_busy t+1..t+4, mdu_wb=1 with mdu_wbreg=9 at t+4 only.
//     rsD=9 stalls through t+4 and is released at t+5.
//  4. Early-out: MDU_LAT=32, mdu_early at t+3 -> mdu_wb at t+4, IDLE at t+5. A second mdu_opD is stalled until t+5.
//  5. exc_flush at t+2 of a busy op -> no mdu_wb, IDLE at t+3. Simultaneous issue+exc_flush -> stays IDLE.
//  6. HAZARD_PERF_EN: 3 load-use + 10 MDU RAW stall cycles -> perf_lw=3, perf_mdu=10. Without the macro all perf_*=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forward-select codes, MDU tracker
// states and the stall-cause indices used by the stall-cycle counters.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    CAUSE_LW  = 2'd0,
    CAUSE_BR  = 2'd1,
    CAUSE_MDU = 2'd2
  } stall_cause_e;

  localparam int NCAUSE = 3;

endpackage

// File: rtl/hazard_sb_mdu_tracker.sv
// Pending-write tracker for the multi-cycle MDU. Holds the destination
// register of the single in-flight MDU op, counts down its latency and
// emits a one-cycle writeback strobe. An exception flush or a reset
// abandons the op without a strobe.
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int RW      = 5,
  parameter int MDU_LAT = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          issue,
  input  logic          early,
  input  logic          excFlush,
  input  logic [RW-1:0] issueReg,
  output mdu_state_e    state,
  output logic [RW-1:0] pd,
  output logic          wb
);

  // Wide enough for MDU_LAT-2 at the top of the legal range (254).
  localparam int CW = 8;

  logic [CW-1:0] cnt;

  // Tracker FSM; wb is registered and is high exactly in the WB state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      pd    <= '0;
      wb    <= 1'b0;
    end else if (excFlush) begin
      // Flush wins over a same-cycle issue and drops any pending write.
      state <= IDLE;
      cnt   <= '0;
      pd    <= '0;
      wb    <= 1'b0;
    end else begin
      wb <= 1'b0;
      case (state)
        IDLE: begin
          // A late issue while not IDLE is impossible (structural stall)
          // and is ignored by only accepting here.
          if (issue) begin
            state <= BUSY;
            pd    <= issueReg;
            cnt   <= CW'(MDU_LAT - 2);
          end
        end
        BUSY: begin
          if (cnt == '0 || early) begin
            state <= WB;
            wb    <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WB: begin
          state <= IDLE;
          pd    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard unit for the 5-stage core: combinational forwarding,
// load-use / branch-compare / MDU scoreboard stalls, and optional
// stall-cycle counters enabled by the HAZARD_PERF_EN macro.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int RW      = $clog2(NREG),
  parameter int MDU_LAT = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic [RW-1:0] writeregD,
  input  logic          regwriteD,
  input  logic          branchD,
  input  logic          mdu_opD,
  input  logic [RW-1:0] rsE,
  input  logic [RW-1:0] rtE,
  input  logic [RW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          mdu_issueE,
  input  logic          mdu_early,
  input  logic [RW-1:0] writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic [RW-1:0] writeregW,
  input  logic          regwriteW,
  input  logic          exc_flush,
  output logic          stallF,
  output logic          stallD,
  output logic          flushE,
  output logic          forwardaD,
  output logic          forwardbD,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          mdu_busy,
  output logic          mdu_wb,
  output logic [RW-1:0] mdu_wbreg,
  output logic [31:0]   perf_lw,
  output logic [31:0]   perf_br,
  output logic [31:0]   perf_mdu
);

  mdu_state_e    mduState;
  logic [RW-1:0] pd;
  logic          lwStall, brStall, mduStall, anyStall, pdValid;

  // Register 0 is hardwired zero, so it never produces a dependency.
  function automatic logic hit(logic [RW-1:0] a, logic [RW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // M is the younger producer, so it takes priority over W.
  function automatic logic [1:0] fwdSel(logic [RW-1:0] src,
                                        logic [RW-1:0] wM, logic rwM,
                                        logic [RW-1:0] wW, logic rwW);
    if (rwM && hit(src, wM)) return FWD_M;
    if (rwW && hit(src, wW)) return FWD_W;
    return FWD_RF;
  endfunction

  mdu_tracker #(.RW(RW), .MDU_LAT(MDU_LAT)) uTracker (
    .clk      (clk),
    .resetn   (resetn),
    .issue    (mdu_issueE),
    .early    (mdu_early),
    .excFlush (exc_flush),
    .issueReg (writeregE),
    .state    (mduState),
    .pd       (pd),
    .wb       (mdu_wb)
  );

  assign mdu_busy  = (mduState != IDLE);
  assign mdu_wbreg = pd;

  assign forwardaD = regwriteM && hit(rsD, writeregM);
  assign forwardbD = regwriteM && hit(rtD, writeregM);
  assign forwardaE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);

  assign lwStall = memtoregE && (hit(rtE, rsD) || hit(rtE, rtD));
  assign brStall = branchD &&
                   ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                    (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));

  // RAW/WAW hold through the WB cycle; the write-first regfile then
  // serves the consumer. A second MDU op waits for the tracker to drain.
  assign pdValid  = mdu_busy && (pd != '0);
  assign mduStall = (pdValid && (rsD == pd || rtD == pd || (regwriteD && writeregD == pd))) ||
                    (mdu_opD && (mdu_busy || mdu_issueE));

  assign anyStall = lwStall || brStall || mduStall;
  assign stallF   = anyStall && !exc_flush;
  assign stallD   = anyStall && !exc_flush;
  assign flushE   = anyStall || exc_flush;

`ifdef HAZARD_PERF_EN
  logic [31:0]       perfCnt [NCAUSE];
  logic [NCAUSE-1:0] cause;

  assign cause[CAUSE_LW]  = lwStall;
  assign cause[CAUSE_BR]  = brStall;
  assign cause[CAUSE_MDU] = mduStall;

  // Independent per-cause stall counters; flushed cycles are not counted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NCAUSE; i++) perfCnt[i] <= '0;
    end else if (!exc_flush) begin
      for (int i = 0; i < NCAUSE; i++)
        if (cause[i]) perfCnt[i] <= perfCnt[i] + 32'd1;
    end
  end

  assign perf_lw  = perfCnt[CAUSE_LW];
  assign perf_br  = perfCnt[CAUSE_BR];
  assign perf_mdu = perfCnt[CAUSE_MDU];
`else
  assign perf_lw  = 32'd0;
  assign perf_br  = 32'd0;
  assign perf_mdu = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: two instances (MDU_LAT 4 and 32) on shared inputs,
// a forwarding/stall vector table, hand sequences for the MDU corner
// cases, then random traffic against a cycle-number based MDU model.
module tb_hazard_sb;
  import hazard_pkg::*;

  localparam int RW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteD, branchD, mdu_opD, regwriteE, memtoregE, mdu_issueE, mdu_early;
  logic regwriteM, memtoregM, regwriteW, exc_flush;

  typedef struct packed {
    logic stallF, stallD, flushE, fwdaD, fwdbD;
    logic [1:0] fwdaE, fwdbE;
    logic busy, wb;
    logic [RW-1:0] wbreg;
    logic [31:0] plw, pbr, pmdu;
  } out_t;

  out_t o [2];

  for (genvar g = 0; g < 2; g++) begin : gDut
    logic sF, sD, fE, faD, fbD, bsy, wbs;
    logic [1:0] faE, fbE;
    logic [RW-1:0] wbr;
    logic [31:0] pl, pb, pm;
    hazard_sb #(.NREG(32), .MDU_LAT(g == 0 ? 4 : 32)) dut (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .writeregD(writeregD), .regwriteD(regwriteD),
      .branchD(branchD), .mdu_opD(mdu_opD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
      .memtoregE(memtoregE), .mdu_issueE(mdu_issueE), .mdu_early(mdu_early),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .writeregW(writeregW), .regwriteW(regwriteW), .exc_flush(exc_flush),
      .stallF(sF), .stallD(sD), .flushE(fE), .forwardaD(faD), .forwardbD(fbD),
      .forwardaE(faE), .forwardbE(fbE), .mdu_busy(bsy), .mdu_wb(wbs),
      .mdu_wbreg(wbr), .perf_lw(pl), .perf_br(pb), .perf_mdu(pm)
    );
    assign o[g] = '{sF, sD, fE, faD, fbD, faE, fbE, bsy, wbs, wbr, pl, pb, pm};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: one MDU op at a time, described by its destination and
  // the absolute cycle number in which its writeback strobe is due.
  int          lat [2] = '{4, 32};
  logic        mAct [2] = '{1'b0, 1'b0};
  logic [RW-1:0] mDest [2];
  longint      mWb [2];
  int unsigned mPerf [2][3];
  longint      cyc = 0;

  function automatic logic dep(logic [RW-1:0] a, logic [RW-1:0] b);
    return a != 0 && a == b;
  endfunction

  // {mdu, br, lw} stall causes for instance k this cycle.
  function automatic logic [2:0] causes(int k);
    logic lw, br, md;
    lw = memtoregE && (dep(rtE, rsD) || dep(rtE, rtD));
    br = branchD && ((regwriteE && (dep(writeregE, rsD) || dep(writeregE, rtD))) ||
                     (memtoregM && (dep(writeregM, rsD) || dep(writeregM, rtD))));
    md = (mAct[k] && mDest[k] != 0 &&
          (rsD == mDest[k] || rtD == mDest[k] || (regwriteD && writeregD == mDest[k]))) ||
         (mdu_opD && (mAct[k] || mdu_issueE));
    return {md, br, lw};
  endfunction

  function automatic logic [1:0] fsel(logic [RW-1:0] s);
    if (regwriteM && dep(s, writeregM)) return 2'b10;
    if (regwriteW && dep(s, writeregW)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compareAll(int k);
    logic [2:0] c;
    logic st, ewb;
    c   = causes(k);
    st  = |c;
    ewb = mAct[k] && cyc == mWb[k];
    chk($sformatf("rnd stallF[%0d] cyc %0d", k, cyc), o[k].stallF, st && !exc_flush);
    chk($sformatf("rnd stallD[%0d] cyc %0d", k, cyc), o[k].stallD, st && !exc_flush);
    chk($sformatf("rnd flushE[%0d] cyc %0d", k, cyc), o[k].flushE, st || exc_flush);
    chk($sformatf("rnd fwdaD[%0d] cyc %0d", k, cyc), o[k].fwdaD, regwriteM && dep(rsD, writeregM));
    chk($sformatf("rnd fwdbD[%0d] cyc %0d", k, cyc), o[k].fwdbD, regwriteM && dep(rtD, writeregM));
    chk($sformatf("rnd fwdaE[%0d] cyc %0d", k, cyc), o[k].fwdaE, fsel(rsE));
    chk($sformatf("rnd fwdbE[%0d] cyc %0d", k, cyc), o[k].fwdbE, fsel(rtE));
    chk($sformatf("rnd busy[%0d] cyc %0d", k, cyc), o[k].busy, mAct[k]);
    chk($sformatf("rnd wb[%0d] cyc %0d", k, cyc), o[k].wb, ewb);
    if (ewb) chk($sformatf("rnd wbreg[%0d] cyc %0d", k, cyc), o[k].wbreg, mDest[k]);
`ifdef HAZARD_PERF_EN
    chk($sformatf("rnd perf_lw[%0d]", k), o[k].plw, mPerf[k][0]);
    chk($sformatf("rnd perf_br[%0d]", k), o[k].pbr, mPerf[k][1]);
    chk($sformatf("rnd perf_mdu[%0d]", k), o[k].pmdu, mPerf[k][2]);
`else
    chk($sformatf("rnd perf_lw[%0d]", k), o[k].plw, 0);
    chk($sformatf("rnd perf_br[%0d]", k), o[k].pbr, 0);
    chk($sformatf("rnd perf_mdu[%0d]", k), o[k].pmdu, 0);
`endif
  endtask

  // Advance the model across the coming edge, then move to just after it.
  task automatic adv();
    for (int k = 0; k < 2; k++) begin
      logic [2:0] c;
      c = causes(k);
      if (!resetn) begin
        mAct[k]  = 1'b0;
        mPerf[k] = '{0, 0, 0};
      end else begin
        if (!exc_flush)
          for (int j = 0; j < 3; j++) if (c[j]) mPerf[k][j]++;
        if (exc_flush) mAct[k] = 1'b0;
        else if (mAct[k] && cyc == mWb[k]) mAct[k] = 1'b0;
        else if (mAct[k] && mdu_early) mWb[k] = cyc + 1;
        else if (!mAct[k] && mdu_issueE) begin
          mAct[k]  = 1'b1;
          mDest[k] = writeregE;
          mWb[k]   = cyc + lat[k];
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; writeregD = 0; regwriteD = 0; branchD = 0; mdu_opD = 0;
    rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0;
    mdu_issueE = 0; mdu_early = 0; writeregM = 0; regwriteM = 0; memtoregM = 0;
    writeregW = 0; regwriteW = 0; exc_flush = 0;
  endtask

  task automatic doReset();
    idle();
    resetn = 1'b0;
    repeat (2) begin @(negedge clk); adv(); end
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [RW-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic brD, rwE, memE, rwM, memM, rwW;
    logic stall, faD, fbD;
    logic [1:0] faE, fbE;
  } vec_t;

  function automatic vec_t mkv(logic [RW-1:0] rsD_, rtD_, rsE_, rtE_, wrE_, wrM_, wrW_,
                               logic brD_, rwE_, memE_, rwM_, memM_, rwW_,
                               logic st_, faD_, fbD_, logic [1:0] faE_, fbE_);
    vec_t v;
    v.rsD = rsD_; v.rtD = rtD_; v.rsE = rsE_; v.rtE = rtE_;
    v.wrE = wrE_; v.wrM = wrM_; v.wrW = wrW_;
    v.brD = brD_; v.rwE = rwE_; v.memE = memE_; v.rwM = rwM_; v.memM = memM_; v.rwW = rwW_;
    v.stall = st_; v.faD = faD_; v.fbD = fbD_; v.faE = faE_; v.fbE = fbE_;
    return v;
  endfunction

  vec_t vt [10];

  initial begin
    //        rsD rtD rsE rtE wrE wrM wrW brD rwE memE rwM memM rwW | st faD fbD faE    fbE
    vt[0] = mkv(0, 0, 5, 0, 0, 5, 5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b10, 2'b00);
    vt[1] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    vt[2] = mkv(0, 0, 0, 6, 0, 7, 6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b01);
    vt[3] = mkv(0, 0, 0, 6, 0, 6, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01);
    vt[4] = mkv(3, 3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00);
    vt[5] = mkv(4, 0, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    vt[6] = mkv(0, 7, 0, 0, 0, 7, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00);
    vt[7] = mkv(0, 7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    vt[8] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vt[9] = mkv(2, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

    // Reset state: all outputs low with idle inputs.
    doReset();
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset outputs[%0d]", k), {o[k].stallF, o[k].stallD, o[k].flushE, o[k].fwdaD,
          o[k].fwdbD, o[k].fwdaE, o[k].fwdbE, o[k].busy, o[k].wb}, 0);
      chk($sformatf("reset perf[%0d]", k), o[k].plw | o[k].pbr | o[k].pmdu, 0);
    end
    adv();

    // Forwarding and branch/load stall vectors.
    for (int i = 0; i < 10; i++) begin
      idle();
      rsD = vt[i].rsD; rtD = vt[i].rtD; rsE = vt[i].rsE; rtE = vt[i].rtE;
      writeregE = vt[i].wrE; writeregM = vt[i].wrM; writeregW = vt[i].wrW;
      branchD = vt[i].brD; regwriteE = vt[i].rwE; memtoregE = vt[i].memE;
      regwriteM = vt[i].rwM; memtoregM = vt[i].memM; regwriteW = vt[i].rwW;
      @(negedge clk);
      chk($sformatf("vec%0d stallD", i), o[0].stallD, vt[i].stall);
      chk($sformatf("vec%0d flushE", i), o[0].flushE, vt[i].stall);
      chk($sformatf("vec%0d fwdaD", i), o[0].fwdaD, vt[i].faD);
      chk($sformatf("vec%0d fwdbD", i), o[0].fwdbD, vt[i].fbD);
      chk($sformatf("vec%0d fwdaE", i), o[0].fwdaE, vt[i].faE);
      chk($sformatf("vec%0d fwdbE", i), o[0].fwdbE, vt[i].fbE);
      adv();
    end

    // Load then use, then W-forward to the consumer in E.
    idle(); memtoregE = 1; regwriteE = 1; rtE = 8; writeregE = 8; rsD = 8;
    @(negedge clk);
    chk("lw stallF", o[0].stallF, 1);
    chk("lw stallD", o[0].stallD, 1);
    chk("lw flushE", o[0].flushE, 1);
    adv();
    idle(); rsE = 8; regwriteW = 1; writeregW = 8;
    @(negedge clk);
    chk("lw stall released", o[0].stallD, 0);
    chk("lw fwdaE W", o[0].fwdaE, 2'b01);
    adv();

    // MDU_LAT=4: issue at t, consumer rsD=9 held through WB.
    doReset();
    idle(); mdu_issueE = 1; writeregE = 9;
    @(negedge clk);
    chk("mdu4 busy@t", o[0].busy, 0);
    adv();
    for (int i = 1; i <= 5; i++) begin
      idle(); rsD = 9;
      @(negedge clk);
      chk($sformatf("mdu4 busy@t+%0d", i), o[0].busy, i <= 4);
      chk($sformatf("mdu4 wb@t+%0d", i), o[0].wb, i == 4);
      chk($sformatf("mdu4 stallD@t+%0d", i), o[0].stallD, i <= 4);
      if (i == 4) chk("mdu4 wbreg", o[0].wbreg, 9);
      adv();
    end

    // MDU_LAT=32 early-out at t+3; a second MDU op waits until t+5.
    doReset();
    idle(); mdu_issueE = 1; writeregE = 12;
    @(negedge clk); adv();
    for (int i = 1; i <= 5; i++) begin
      idle(); mdu_opD = 1; mdu_early = (i == 3);
      @(negedge clk);
      chk($sformatf("early busy@t+%0d", i), o[1].busy, i <= 4);
      chk($sformatf("early wb@t+%0d", i), o[1].wb, i == 4);
      chk($sformatf("early stallD@t+%0d", i), o[1].stallD, i <= 4);
      if (i == 4) chk("early wbreg", o[1].wbreg, 12);
      adv();
    end

    // Exception mid-op: no writeback, IDLE next cycle.
    doReset();
    idle(); mdu_issueE = 1; writeregE = 9;
    @(negedge clk); adv();
    idle(); @(negedge clk); adv();
    idle(); exc_flush = 1; rsD = 9;
    @(negedge clk);
    chk("exc flushE", o[0].flushE, 1);
    chk("exc stallD", o[0].stallD, 0);
    adv();
    for (int i = 3; i <= 4; i++) begin
      idle(); rsD = 9;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("exc busy[%0d]@t+%0d", k, i), o[k].busy, 0);
        chk($sformatf("exc wb[%0d]@t+%0d", k, i), o[k].wb, 0);
        chk($sformatf("exc stallD[%0d]@t+%0d", k, i), o[k].stallD, 0);
      end
      adv();
    end
    // Issue together with exc_flush is dropped.
    idle(); mdu_issueE = 1; exc_flush = 1; writeregE = 9;
    @(negedge clk); adv();
    idle(); rsD = 9;
    @(negedge clk);
    chk("exc+issue busy", o[0].busy, 0);
    chk("exc+issue stallD", o[0].stallD, 0);
    adv();

    // Stall counters: 3 load-use cycles then 10 MDU RAW cycles.
    doReset();
    repeat (3) begin
      idle(); memtoregE = 1; rtE = 8; rsD = 8;
      @(negedge clk); adv();
    end
    idle(); mdu_issueE = 1; writeregE = 9;
    @(negedge clk); adv();
    repeat (10) begin
      idle(); rsD = 9;
      @(negedge clk); adv();
    end
    idle();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_lw lat32", o[1].plw, 3);
    chk("perf_mdu lat32", o[1].pmdu, 10);
    chk("perf_br lat32", o[1].pbr, 0);
    chk("perf_lw lat4", o[0].plw, 3);
    chk("perf_mdu lat4", o[0].pmdu, 4);
`else
    chk("perf_lw off", o[1].plw, 0);
    chk("perf_mdu off", o[1].pmdu, 0);
    chk("perf_br off", o[1].pbr, 0);
`endif
    adv();

    // Random traffic against the model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      rsD = RW'($urandom_range(0, 7)); rtD = RW'($urandom_range(0, 7));
      writeregD = RW'($urandom_range(0, 7)); regwriteD = ($urandom_range(0, 1) == 1);
      branchD = ($urandom_range(0, 3) == 0); mdu_opD = ($urandom_range(0, 7) == 0);
      rsE = RW'($urandom_range(0, 7)); rtE = RW'($urandom_range(0, 7));
      writeregE = RW'($urandom_range(0, 7)); regwriteE = ($urandom_range(0, 1) == 1);
      memtoregE = ($urandom_range(0, 3) == 0); mdu_issueE = ($urandom_range(0, 5) == 0);
      mdu_early = ($urandom_range(0, 15) == 0);
      writeregM = RW'($urandom_range(0, 7)); regwriteM = ($urandom_range(0, 1) == 1);
      memtoregM = ($urandom_range(0, 3) == 0);
      writeregW = RW'($urandom_range(0, 7)); regwriteW = ($urandom_range(0, 1) == 1);
      exc_flush = ($urandom_range(0, 39) == 0);
      resetn = ($urandom_range(0, 299) != 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) compareAll(k);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
